mem_lsu: RTL and testbench



---
 rtl/mem_lsu_if.sv | 42 ++++
 rtl/mem_lsu.sv | 144 ++++++++++++++
 tb/tb_mem_lsu.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: groups the EX/MEM request, RAM port and MEM/WB result
// signals of the memory-stage load/store unit.
//   req_*        : instruction from EX/MEM (load/store/size/addr/data/wb fields)
//   ram_*        : 8-bit synchronous RAM port (ram_din valid one cycle after addr)
//   mem_*        : result towards MEM/WB
//   stallreq     : pipeline hold request towards ctrl
//   misalign_err : misaligned-access pulse
// slave modport is the LSU; master modport is the pipeline/RAM side.
interface mem_lsu_if;
  logic        req_load;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_sdata;
  logic [4:0]  req_wd;
  logic        req_wreg;
  logic [31:0] req_wdata;
  logic [7:0]  ram_din;
  logic [31:0] ram_addr;
  logic [7:0]  ram_dout;
  logic        ram_we;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        stallreq;
  logic        misalign_err;

  modport slave (
    input  req_load, req_store, req_size, req_unsigned, req_addr, req_sdata,
           req_wd, req_wreg, req_wdata, ram_din,
    output ram_addr, ram_dout, ram_we, mem_wd, mem_wreg, mem_wdata,
           stallreq, misalign_err
  );

  modport master (
    output req_load, req_store, req_size, req_unsigned, req_addr, req_sdata,
           req_wd, req_wreg, req_wdata, ram_din,
    input  ram_addr, ram_dout, ram_we, mem_wd, mem_wreg, mem_wdata,
           stallreq, misalign_err
  );
endinterface

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit. Non-memory instructions pass
// straight through to MEM/WB; loads and stores run byte-serially on an
// 8-bit synchronous RAM while stallreq holds the pipeline.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high; forces all outputs to 0
//   bus  : mem_lsu_if.slave (request, RAM port, MEM/WB result, stallreq,
//          misalign_err)
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no RAM cycles, one-cycle misalign_err pulse).
module mem_lsu (
  input  logic      clk,
  input  logic      rst,
  mem_lsu_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] rd_buf;
  logic [1:0]  last_idx;
  logic        is_mem;
  logic        misaligned;
  logic        go_mem;
  logic [31:0] load_ext;

  // Index of the final byte: N-1 for N = 1, 2, 4.
  always_comb begin
    case (bus.req_size)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'd0));
`else
  assign misaligned = 1'b0;
`endif

  assign is_mem = bus.req_load | bus.req_store;
  assign go_mem = is_mem & ~misaligned;

  // Sign/zero extension of the assembled load data.
  always_comb begin
    case (bus.req_size)
      2'd0:    load_ext = bus.req_unsigned ? {24'd0, rd_buf[7:0]}
                                           : {{24{rd_buf[7]}}, rd_buf[7:0]};
      2'd1:    load_ext = bus.req_unsigned ? {16'd0, rd_buf[15:0]}
                                           : {{16{rd_buf[15]}}, rd_buf[15:0]};
      default: load_ext = rd_buf;
    endcase
  end

  // State, byte counter and little-endian read buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      rd_buf <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (go_mem) begin
            if (bus.req_load) begin
              cnt   <= 2'd0;
              state <= RD;
            end else if (last_idx == 2'd0) begin
              state <= DONE;
            end else begin
              cnt   <= 2'd1;
              state <= WR;
            end
          end
        end
        RD: begin
          rd_buf[{cnt, 3'b000} +: 8] <= bus.ram_din;
          if (cnt == last_idx) state <= DONE;
          else                 cnt   <= cnt + 2'd1;
        end
        WR: begin
          if (cnt == last_idx) state <= DONE;
          else                 cnt   <= cnt + 2'd1;
        end
        default: begin
          cnt   <= 2'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs; IDLE pass-through and address issue are combinational so
  // non-memory instructions add no latency.
  always_comb begin
    bus.ram_addr     = 32'd0;
    bus.ram_dout     = 8'd0;
    bus.ram_we       = 1'b0;
    bus.mem_wd       = 5'd0;
    bus.mem_wreg     = 1'b0;
    bus.mem_wdata    = 32'd0;
    bus.stallreq     = 1'b0;
    bus.misalign_err = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (go_mem) begin
            bus.ram_addr = bus.req_addr;
            bus.stallreq = 1'b1;
            if (bus.req_store) begin
              bus.ram_we   = 1'b1;
              bus.ram_dout = bus.req_sdata[7:0];
            end
          end else if (is_mem) begin
            bus.misalign_err = 1'b1;
          end else begin
            bus.mem_wd    = bus.req_wd;
            bus.mem_wreg  = bus.req_wreg;
            bus.mem_wdata = bus.req_wdata;
          end
        end
        RD: begin
          bus.stallreq = 1'b1;
          if (cnt != last_idx) bus.ram_addr = bus.req_addr + 32'(cnt) + 32'd1;
        end
        WR: begin
          bus.stallreq = 1'b1;
          bus.ram_we   = 1'b1;
          bus.ram_addr = bus.req_addr + 32'(cnt);
          bus.ram_dout = bus.req_sdata[{cnt, 3'b000} +: 8];
        end
        default: begin
          bus.mem_wd    = bus.req_wd;
          bus.mem_wreg  = bus.req_wreg;
          bus.mem_wdata = bus.req_load ? load_ext : bus.req_wdata;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: self-checking bench for mem_lsu. A byte-addressed RAM model
// answers the DUT's RAM port; a separate reference memory plus per-operation
// timing rules give the expected outputs for every cycle of each operation.
module tb_mem_lsu;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_lsu_if bus ();

  mem_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] ram     [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  int compared   = 0;
  int mismatched = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Synchronous RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    bus.ram_din <= ram_rd(bus.ram_addr);
    if (bus.ram_we) ram[bus.ram_addr] = bus.ram_dout;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_req(input logic ld, input logic st, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] sd,
                           input logic [4:0] wd, input logic wr, input logic [31:0] wdat);
    bus.req_load     = ld;
    bus.req_store    = st;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_sdata    = sd;
    bus.req_wd       = wd;
    bus.req_wreg     = wr;
    bus.req_wdata    = wdat;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_stall"}, bus.stallreq, 1'b0);
    chk1({tag, "_we"}, bus.ram_we, 1'b0);
    chk({tag, "_addr"}, bus.ram_addr, 32'd0);
    chk({tag, "_dout"}, 32'(bus.ram_dout), 32'd0);
    chk({tag, "_wd"}, 32'(bus.mem_wd), 32'd0);
    chk1({tag, "_wreg"}, bus.mem_wreg, 1'b0);
    chk({tag, "_wdata"}, bus.mem_wdata, 32'd0);
    chk1({tag, "_err"}, bus.misalign_err, 1'b0);
  endtask

  // Issue one instruction at the next clock edge and check every cycle up to
  // and including the one where the MEM/WB result is valid.
  task automatic run_op(input logic ld, input logic st, input logic [1:0] sz,
                        input logic uns, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] wd, input logic wr, input logic [31:0] wdat,
                        output logic [31:0] got);
    int n;
    bit trap;
    logic [31:0] exp_v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = (ld || st) && (((sz == 2'd1) && a[0]) || ((sz >= 2'd2) && (a[1:0] != 2'd0)));
`endif
    @(posedge clk);
    #1;
    drive_req(ld, st, sz, uns, a, sd, wd, wr, wdat);
    got = 32'd0;
    if (trap) begin
      @(negedge clk);
      chk1("trap_err", bus.misalign_err, 1'b1);
      chk1("trap_stall", bus.stallreq, 1'b0);
      chk1("trap_we", bus.ram_we, 1'b0);
      chk1("trap_wreg", bus.mem_wreg, 1'b0);
      chk("trap_wd", 32'(bus.mem_wd), 32'd0);
      chk("trap_wdata", bus.mem_wdata, 32'd0);
      got = bus.mem_wdata;
    end else if (!ld && !st) begin
      @(negedge clk);
      chk("alu_wd", 32'(bus.mem_wd), 32'(wd));
      chk1("alu_wreg", bus.mem_wreg, wr);
      chk("alu_wdata", bus.mem_wdata, wdat);
      chk1("alu_stall", bus.stallreq, 1'b0);
      chk1("alu_we", bus.ram_we, 1'b0);
      got = bus.mem_wdata;
    end else if (ld) begin
      exp_v = 32'd0;
      for (int k = 0; k < n; k++)
        exp_v = exp_v | (32'(ref_rd(a + 32'(k))) << (8 * k));
      if (n < 4 && !uns && exp_v[8*n-1])
        exp_v = exp_v | ~((32'd1 << (8 * n)) - 32'd1);
      for (int k = 0; k <= n; k++) begin
        @(negedge clk);
        chk1("ld_stall", bus.stallreq, 1'b1);
        chk1("ld_we", bus.ram_we, 1'b0);
        if (k < n) chk("ld_addr", bus.ram_addr, a + 32'(k));
      end
      @(negedge clk);
      chk1("ld_done_stall", bus.stallreq, 1'b0);
      chk1("ld_done_we", bus.ram_we, 1'b0);
      chk("ld_done_wd", 32'(bus.mem_wd), 32'(wd));
      chk1("ld_done_wreg", bus.mem_wreg, wr);
      chk("ld_done_wdata", bus.mem_wdata, exp_v);
      got = bus.mem_wdata;
    end else begin
      for (int k = 0; k < n; k++) begin
        @(negedge clk);
        chk1("st_stall", bus.stallreq, 1'b1);
        chk1("st_we", bus.ram_we, 1'b1);
        chk("st_addr", bus.ram_addr, a + 32'(k));
        chk("st_dout", 32'(bus.ram_dout), 32'(sd[8*k +: 8]));
        ref_mem[a + 32'(k)] = sd[8*k +: 8];
      end
      @(negedge clk);
      chk1("st_done_stall", bus.stallreq, 1'b0);
      chk1("st_done_we", bus.ram_we, 1'b0);
      chk("st_done_wd", 32'(bus.mem_wd), 32'(wd));
      chk1("st_done_wreg", bus.mem_wreg, wr);
      chk("st_done_wdata", bus.mem_wdata, wdat);
      got = bus.mem_wdata;
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [7:0] v);
    ram[a]     = v;
    ref_mem[a] = v;
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] a;
    int kind;
    logic [1:0] sz;

    rst = 1'b1;
    bus.ram_din = 8'h00;
    drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 5'd3, 1'b1, 32'hDEAD_BEEF);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);

    // Directed cases with literal results.
    run_op(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h1234, got);
    chk("alu_lit", got, 32'h0000_1234);

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd7, 1'b1, 32'h0, got);
    chk("lw_lit", got, 32'h4433_2211);

    preload(32'h7, 8'h80);
    run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h7, 32'h0, 5'd8, 1'b1, 32'h0, got);
    chk("lb_lit", got, 32'hFFFF_FF80);
    run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 5'd8, 1'b1, 32'h0, got);
    chk("lbu_lit", got, 32'h0000_0080);

    run_op(1'b0, 1'b1, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0000_ABCD, 5'd0, 1'b0, 32'h55, got);
    chk("sh_wrap_lo", 32'(ram_rd(32'hFFFF_FFFF)), 32'h0000_00CD);
    chk("sh_wrap_hi", 32'(ram_rd(32'h0)), 32'h0000_00AB);
    run_op(1'b1, 1'b0, 2'd1, 1'b1, 32'hFFFF_FFFF, 32'h0, 5'd9, 1'b1, 32'h0, got);
    chk("lhu_wrap_lit", got, 32'h0000_ABCD);
    run_op(1'b1, 1'b0, 2'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 5'd9, 1'b1, 32'h0, got);
    chk("lh_wrap_lit", got, 32'hFFFF_ABCD);

    // Misaligned word load: trapped or byte-serial from 0x102.
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd4, 1'b1, 32'h0, got);
`ifndef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_lit", got, 32'h0000_4433);
`endif

    // Reset during the third byte of a word load.
    preload(32'h200, 8'hA1); preload(32'h201, 8'hB2);
    preload(32'h202, 8'hC3); preload(32'h203, 8'hD4);
    @(posedge clk);
    #1;
    drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd6, 1'b1, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_req(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk_all_zero("postrst");
    run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 5'd6, 1'b1, 32'h0, got);
    chk("lw_after_rst_lit", got, 32'hD4C3_B2A1);

    // Randomized mix over a small window plus the wrap-around corner.
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 2));
      sz   = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           a = 32'h1000 + 32'($urandom_range(0, 31));
      run_op(kind == 1, kind == 2, sz, 1'($urandom_range(0, 1)), a, $urandom(),
             5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom(), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
